div_issue_ctrl: RTL

RISC-V M-extension divide sequencer sitting directly upstream of the team's IP-core divider, between the EX stage and the divider. It accepts one DIV/DIVU/REM/REMU request and holds operands stable on the always-valid divider inputs. It waits the divider's fixed pipeline latency, then selects quotient or remainder. It resolves RISC-V special cases (divide-by-zero, signed overflow) locally without waiting, and gives the pipeline a busy/done handshake for stalling.

---
 rtl/div_issue_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_issue_ctrl
// Description : RISC-V DIV/DIVU/REM/REMU sequencer in front of a fixed-latency
//               divider. Special cases are resolved locally in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
    parameter int DIV_LATENCY = 36
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] div_number1,
    output logic [31:0] div_number2,
    output logic        div_sign_mode,
    input  logic [31:0] div_ans,
    input  logic [31:0] div_remind
);

    localparam int c_CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DIV_LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_result;
    logic [31:0]        r_number1;
    logic [31:0]        r_number2;
    logic               r_sign_mode;
    logic               r_rem_sel;

    logic        w_accept;
    logic        w_div_by_zero;
    logic        w_overflow;
    logic        w_special;
    logic [31:0] w_special_result;
    logic        w_unused;

    // The divide/rem family is fully identified by funct3[1:0]; bit 2 is implied.
    assign w_unused = funct3[2];

    // A flush in the same cycle as start drops the request.
    assign w_accept      = start && !flush && (r_state != c_WAIT);
    assign w_div_by_zero = (rs2 == 32'h0);
    assign w_overflow    = !funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign w_special     = w_div_by_zero || w_overflow;

    assign w_special_result = w_div_by_zero ? (funct3[1] ? rs1   : 32'hFFFF_FFFF)
                                            : (funct3[1] ? 32'h0 : 32'h8000_0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= 32'h0;
            r_number1   <= 32'h0;
            r_number2   <= 32'h0;
            r_sign_mode <= 1'b0;
            r_rem_sel   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_WAIT: begin
                    if (flush) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_result <= r_rem_sel ? div_remind : div_ans;
                        r_state  <= c_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                // IDLE and DONE both accept; DONE accepting gives back-to-back issue.
                default: begin
                    if (w_accept) begin
                        r_number1   <= rs1;
                        r_number2   <= rs2;
                        r_sign_mode <= funct3[0];
                        r_rem_sel   <= funct3[1];
                        if (w_special) begin
                            r_result <= w_special_result;
                            r_state  <= c_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_state <= c_WAIT;
                            r_busy  <= 1'b1;
                            r_cnt   <= c_CNT_LOAD;
                        end
                    end else begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign result        = r_result;
    assign div_number1   = r_number1;
    assign div_number2   = r_number2;
    assign div_sign_mode = r_sign_mode;

endmodule
`default_nettype wire
